// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video scanout reads win, CPU writes are posted
// through a small FIFO, and CPU reads wait for the FIFO to drain.
module vram_arbiter #(
  parameter int AW     = 16,
  parameter int DEPTH  = 4,
  parameter int STARVE = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cpu_req,
  input  logic                       cpu_wren,
  input  logic [AW-1:0]              cpu_addr,
  input  logic [7:0]                 cpu_wdata,
  output logic [7:0]                 cpu_rdata,
  output logic                       cpu_stall,
  input  logic                       vid_req,
  input  logic [AW-1:0]              vid_addr,
  output logic                       vid_ack,
  output logic [7:0]                 vid_rdata,
  output logic [AW-1:0]              mem_addr,
  output logic                       mem_wren,
  output logic [7:0]                 mem_wdata,
  input  logic [7:0]                 mem_rdata,
  output logic [$clog2(DEPTH):0]     wbuf_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = $clog2(STARVE + 1);

  typedef enum logic [1:0] {IDLE, RD_PEND, RD_DATA, RD_DONE} rd_state_t;

  rd_state_t       rd_state;
  logic [AW-1:0]   wbuf_addr [DEPTH];
  logic [7:0]      wbuf_data [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [SW-1:0]   starve_cnt;

  logic full, empty, w_elig, r_elig, cpu_side, override;
  logic grant_v, grant_w, grant_r, push, pop;

  assign full  = (wbuf_level == LW'(DEPTH));
  assign empty = (wbuf_level == '0);

  // Pending CPU work is frozen while reset is high so discarded writes never reach RAM.
  assign w_elig   = ~reset & ~empty;
  assign r_elig   = ~reset & (rd_state == RD_PEND) & empty;
  assign cpu_side = w_elig | r_elig;
  assign override = cpu_side & (starve_cnt == SW'(STARVE));

  assign grant_v = vid_req & ~override;
  assign grant_w = w_elig & ~grant_v;
  assign grant_r = r_elig & ~w_elig & ~grant_v;

  assign push = ~reset & cpu_req & cpu_wren & ~full;
  assign pop  = grant_w;

  always_comb begin
    mem_addr  = vid_addr;
    mem_wren  = 1'b0;
    mem_wdata = 8'h00;
    if (grant_w) begin
      mem_addr  = wbuf_addr[head_ptr];
      mem_wren  = 1'b1;
      mem_wdata = wbuf_data[head_ptr];
    end else if (grant_r) begin
      mem_addr = cpu_addr;
    end
  end

  assign cpu_stall = reset
                   | (cpu_req & cpu_wren & full)
                   | ((rd_state == IDLE) & cpu_req & ~cpu_wren)
                   | (rd_state == RD_PEND)
                   | (rd_state == RD_DATA);

  assign vid_rdata = mem_rdata;

  always_ff @(posedge clock) begin
    if (push) begin
      wbuf_addr[tail_ptr] <= cpu_addr;
      wbuf_data[tail_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      wbuf_level <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      case ({push, pop})
        2'b10:   wbuf_level <= wbuf_level + LW'(1);
        2'b01:   wbuf_level <= wbuf_level - LW'(1);
        default: wbuf_level <= wbuf_level;
      endcase
      // Counts video wins only while the CPU side is actually waiting.
      if (!cpu_side || grant_w || grant_r)
        starve_cnt <= '0;
      else if (grant_v && starve_cnt != SW'(STARVE))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state  <= IDLE;
      cpu_rdata <= 8'h00;
      vid_ack   <= 1'b0;
    end else begin
      vid_ack <= grant_v;
      case (rd_state)
        IDLE:    if (cpu_req && !cpu_wren) rd_state <= RD_PEND;
        RD_PEND: if (grant_r) rd_state <= RD_DATA;
        RD_DATA: begin
          cpu_rdata <= mem_rdata;
          rd_state  <= RD_DONE;
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM (text/graphics bank behind the F000h window) between the AVR CPU bus and the VGA scanout fetcher.
- Video reads have priority. A starvation counter bounds how long the CPU side can be delayed.
- CPU writes are posted into a small write buffer so the CPU normally does not stall on writes.
- CPU reads stall the CPU until the buffer has drained and the read data has returned.

Parameters:
- AW, 16, address width of CPU, video and memory buses
- DEPTH, 4, write-buffer entries; must be a power of two, at least 2
- STARVE, 8, maximum consecutive video grants while CPU-side work is pending

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access valid this cycle; held high by the CPU while cpu_stall=1
- cpu_wren  in  1  1=write, 0=read; qualifies cpu_req
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, registered; valid in the cycle a read completes
- cpu_stall  out  1  combinational; CPU must hold its request while high
- vid_req  in  1  scanout read request, level
- vid_addr  in  AW  scanout read address
- vid_ack  out  1  registered one-cycle pulse; vid_rdata valid this cycle
- vid_rdata  out  8  equals mem_rdata
- mem_addr  out  AW  RAM address, combinational from grant
- mem_wren  out  1  RAM write enable, combinational from grant
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, valid 1 cycle after a read is issued
- wbuf_level  out  log2(DEPTH)+1  current write-buffer occupancy, registered

Behaviour:
- Memory slot: at most one RAM operation per cycle. Candidates are:
  - V: video read, when vid_req=1.
  - W: buffer head write, when the buffer is not empty.
  - R: CPU read, when the read FSM is in RD_PEND and the buffer is empty.
- Priority is V > W > R, with one override: if starve_cnt==STARVE and W or R is eligible, the CPU side wins that slot. In that case W is taken before R.
- starve_cnt:
  - Increments on each V grant while W or R is eligible.
  - Clears on any W or R grant.
  - Clears whenever neither W nor R is eligible.
  - Saturates at STARVE.
- No grant: mem_addr=vid_addr, mem_wren=0, mem_wdata=0.
- Write buffer:
  - FIFO of {addr,data}; full/empty are derived from registered wbuf_level.
  - Push when cpu_req & cpu_wren & ~full.
  - cpu_req & cpu_wren & full gives cpu_stall=1 and no push, even if a pop happens the same cycle.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo DEPTH.
- Read FSM, states IDLE, RD_PEND, RD_DATA, RD_DONE:
  - IDLE: cpu_req & ~cpu_wren goes to RD_PEND; cpu_stall=1.
  - RD_PEND: cpu_stall=1. When R is granted, mem_addr=cpu_addr and the FSM goes to RD_DATA.
  - RD_DATA: cpu_stall=1. cpu_rdata is loaded from mem_rdata; go to RD_DONE.
  - RD_DONE: cpu_stall=0, the CPU consumes cpu_rdata; go to IDLE.
  - Minimum read stall is 3 cycles; the read completes in the 4th cycle.
  - Reads are ordered after all earlier buffered writes because R requires an empty buffer.
- Video: a V grant in cycle N gives vid_ack=1 in N+1 with vid_rdata=mem_rdata. Back-to-back vid_req gives one grant per cycle.
- Reset:
  - Buffer is emptied and pending writes are discarded.
  - wbuf_level=0, FSM=IDLE, starve_cnt=0, cpu_rdata=0, vid_ack=0.
  - cpu_stall=1 while reset is high.
  - Reset during a read abandons it. After reset the CPU re-presents the request and it starts over from IDLE.

Test Plan:
- CPU writes 3 bytes (F000h←11h, F001h←22h, F002h←33h) back-to-back, vid_req=0 -> cpu_stall stays 0; mem_wren pulses in cycles 1,2,3 with matching addr/data; wbuf_level peaks at 1.
- vid_req held high, DEPTH+1 CPU writes -> 5th write stalls (cpu_stall=1) while wbuf_level=4. After 8 consecutive V grants the head write is issued (mem_wren=1); the stalled write pushes the next cycle.
- Buffer holds 2 writes incl. F005h←A5h, then CPU reads F005h, no video -> both writes issue first, read issues next; cpu_rdata=A5h when cpu_stall drops.
- CPU read of idle RAM word F010h=5Ah, no video -> cpu_stall high exactly 3 cycles, cpu_rdata=5Ah in the 4th.
- Video stream F100h..F10Fh with vid_req held -> vid_ack every cycle one cycle after each address; vid_rdata matches RAM contents.
- Reset asserted in RD_DATA with 2 buffered writes -> next cycle wbuf_level=0, vid_ack=0, no mem_wren; after release, a new read completes normally.
